// File: rtl/down_ctr_timer.sv
// -----------------------------------------------------------------------------
// down_ctr_timer
//
// Loadable down-counter used as an interval / terminal-count timer.
// It supports one-shot and auto-reload operation. A load writes both the live
// count and a reload register. Start moves the IDLE controller into RUN.
// While in RUN, each enabled edge decrements the count. On the edge where the
// count leaves 1, a single-cycle tc pulse is raised. In auto-reload mode the
// count is then refilled from the reload register; otherwise the counter
// returns to IDLE at zero. All outputs are registered.
//
// Ports:
//   clk          in   system clock, rising-edge active
//   reset        in   synchronous active-high reset, highest priority
//   load         in   capture load_val into count and reload register, abort run
//   load_val     in   [WIDTH]  value captured on load
//   start        in   begin counting from the current count (IDLE only)
//   en           in   count enable; 0 pauses while in RUN
//   auto_reload  in   1 = refill from reload register at terminal count
//   count        out  [WIDTH]  current counter value
//   busy         out  high while in RUN
//   tc           out  one-cycle terminal-count pulse
// -----------------------------------------------------------------------------
module down_ctr_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             tc_q, tc_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        busy_d   = busy_q;
        tc_d     = 1'b0;

        if (load) begin
            // A load always wins over start/count and silently aborts a run.
            count_d  = load_val;
            reload_d = load_val;
            state_d  = IDLE;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Starting from zero has nothing to count: report
                        // terminal count immediately and stay idle.
                        if (count_q == '0) begin
                            tc_d = 1'b1;
                        end else begin
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            // Terminal edge. A zero reload value cannot
                            // sustain a period, so it falls back to one-shot.
                            tc_d = 1'b1;
                            if (auto_reload && (reload_q != '0)) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_down_ctr_timer.sv
// -----------------------------------------------------------------------------
// tb_down_ctr_timer
//
// Self-checking bench for down_ctr_timer (WIDTH=4). Directed scenario tasks
// check the expected count/busy/tc sequences. A randomized phase then compares
// the DUT cycle by cycle against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_down_ctr_timer;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         busy;
    logic         tc;

    int checks   = 0;
    int failures = 0;

    down_ctr_timer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .en          (en),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .tc          (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset       = 1'b0;
        load        = 1'b0;
        load_val    = '0;
        start       = 1'b0;
        en          = 1'b0;
        auto_reload = 1'b0;
    endtask

    task automatic do_load(input int v);
        load     = 1'b1;
        load_val = W'(v);
        tick();
        load     = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset    = 1'b1;
        load     = 1'b1;
        load_val = W'(9);
        start    = 1'b1;
        en       = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (count !== W'(0) || busy !== 1'b0 || tc !== 1'b0) begin
                failures++;
                $display("FAIL reset cyc=%0d got count=%0d busy=%b tc=%b want count=0 busy=0 tc=0",
                         i, count, busy, tc);
            end
        end
        idle_inputs();
        do_load(9);
        checks++;
        if (count !== W'(9) || busy !== 1'b0 || tc !== 1'b0) begin
            failures++;
            $display("FAIL reset_load got count=%0d busy=%b tc=%b want count=9 busy=0 tc=0",
                     count, busy, tc);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_one_shot();
        int exp_c [6] = '{5, 4, 3, 2, 1, 0};
        bit exp_b [6] = '{1, 1, 1, 1, 1, 0};
        bit exp_t [6] = '{0, 0, 0, 0, 0, 1};
        idle_inputs();
        do_load(5);
        start       = 1'b1;
        en          = 1'b1;
        auto_reload = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 1'b0;
            checks++;
            if (count !== W'(exp_c[i]) || busy !== exp_b[i] || tc !== exp_t[i]) begin
                failures++;
                $display("FAIL one_shot edge=k+%0d got count=%0d busy=%b tc=%b want count=%0d busy=%b tc=%b",
                         i, count, busy, tc, exp_c[i], exp_b[i], exp_t[i]);
            end
        end
        tick();
        checks++;
        if (count !== W'(0) || busy !== 1'b0 || tc !== 1'b0) begin
            failures++;
            $display("FAIL one_shot_after got count=%0d busy=%b tc=%b want count=0 busy=0 tc=0",
                     count, busy, tc);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_auto_reload();
        int exp_c [10] = '{3, 2, 1, 3, 2, 1, 3, 2, 1, 0};
        bit exp_b [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        bit exp_t [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        idle_inputs();
        do_load(3);
        start       = 1'b1;
        en          = 1'b1;
        auto_reload = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            start = 1'b0;
            // Drop auto_reload after the second reload so the third
            // terminal edge finishes the run.
            if (i == 6) auto_reload = 1'b0;
            checks++;
            if (count !== W'(exp_c[i]) || busy !== exp_b[i] || tc !== exp_t[i]) begin
                failures++;
                $display("FAIL auto_reload step=%0d got count=%0d busy=%b tc=%b want count=%0d busy=%b tc=%b",
                         i, count, busy, tc, exp_c[i], exp_b[i], exp_t[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_pause();
        int exp_c [8] = '{4, 3, 2, 2, 2, 2, 1, 0};
        bit exp_b [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        bit exp_t [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        bit en_s  [8] = '{1, 1, 0, 0, 0, 1, 1, 0};
        idle_inputs();
        do_load(4);
        start = 1'b1;
        en    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            en    = en_s[i];
            checks++;
            if (count !== W'(exp_c[i]) || busy !== exp_b[i] || tc !== exp_t[i]) begin
                failures++;
                $display("FAIL pause step=%0d got count=%0d busy=%b tc=%b want count=%0d busy=%b tc=%b",
                         i, count, busy, tc, exp_c[i], exp_b[i], exp_t[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_abort();
        idle_inputs();
        do_load(6);
        start = 1'b1;
        en    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (count !== W'(4) || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre got count=%0d busy=%b want count=4 busy=1", count, busy);
        end
        do_load(2);
        checks++;
        if (count !== W'(2) || busy !== 1'b0 || tc !== 1'b0) begin
            failures++;
            $display("FAIL abort_load got count=%0d busy=%b tc=%b want count=2 busy=0 tc=0",
                     count, busy, tc);
        end
        tick();
        checks++;
        if (count !== W'(2) || busy !== 1'b0 || tc !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold got count=%0d busy=%b tc=%b want count=2 busy=0 tc=0",
                     count, busy, tc);
        end
        do_load(6);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (count !== W'(0) || busy !== 1'b0 || tc !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset got count=%0d busy=%b tc=%b want count=0 busy=0 tc=0",
                     count, busy, tc);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_zero_max();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        en    = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (count !== W'(0) || busy !== 1'b0 || tc !== 1'b1) begin
            failures++;
            $display("FAIL zero_start got count=%0d busy=%b tc=%b want count=0 busy=0 tc=1",
                     count, busy, tc);
        end
        tick();
        checks++;
        if (tc !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_tc_width got tc=%b busy=%b want tc=0 busy=0", tc, busy);
        end
        do_load(15);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (count !== W'(15) || busy !== 1'b1) begin
            failures++;
            $display("FAIL max_start got count=%0d busy=%b want count=15 busy=1", count, busy);
        end
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if (count !== W'(15 - i) || busy !== (i != 15) || tc !== (i == 15)) begin
                failures++;
                $display("FAIL max_count enabled=%0d got count=%0d busy=%b tc=%b want count=%0d busy=%b tc=%b",
                         i, count, busy, tc, 15 - i, (i != 15), (i == 15));
            end
        end
        tick();
        checks++;
        if (count !== W'(0) || busy !== 1'b0 || tc !== 1'b0) begin
            failures++;
            $display("FAIL max_nowrap got count=%0d busy=%b tc=%b want count=0 busy=0 tc=0",
                     count, busy, tc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a timer holding a value and a period. While it is
    // running it loses one unit per enabled cycle. Reaching the end fires tc.
    task automatic test_random();
        int  m_val, m_period;
        bit  m_running, e_tc;
        idle_inputs();
        reset = 1'b1;
        tick();
        m_val = 0; m_period = 0; m_running = 0;
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            load        = ($urandom_range(0, 9) == 0);
            load_val    = W'($urandom_range(0, 15));
            start       = ($urandom_range(0, 3) == 0);
            en          = ($urandom_range(0, 3) != 0);
            auto_reload = $urandom_range(0, 1) == 1;

            e_tc = 0;
            if (reset) begin
                m_val = 0; m_period = 0; m_running = 0;
            end else if (load) begin
                m_val = int'(load_val); m_period = int'(load_val); m_running = 0;
            end else if (!m_running) begin
                if (start) begin
                    if (m_val == 0) e_tc = 1;
                    else m_running = 1;
                end
            end else if (en) begin
                m_val = m_val - 1;
                if (m_val == 0) begin
                    e_tc = 1;
                    if (auto_reload && m_period > 0) m_val = m_period;
                    else m_running = 0;
                end
            end

            tick();
            checks++;
            if (count !== W'(m_val) || busy !== m_running || tc !== e_tc) begin
                failures++;
                $display("FAIL random cyc=%0d got count=%0d busy=%b tc=%b want count=%0d busy=%b tc=%b",
                         i, count, busy, tc, m_val, m_running, e_tc);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause();
        test_abort();
        test_zero_max();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
